// File: rtl/hazard_detection_unit.sv
// Load-use stall and taken-branch flush control beside the ID stage.
// Control outputs are combinational from ID inputs and registered EX shadow; state updates on the clk edge.
module hazard_detection_unit #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_id,
  input  logic             uses_rs1_id,
  input  logic             uses_rs2_id,
  input  logic             RuWr_id,
  input  logic             DMRd_id,
  input  logic             br_taken_ex,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

  localparam bit         MULTI_STALL = (LOAD_LAT > 1);
  localparam logic [2:0] LAT_INIT    = MULTI_STALL ? 3'(LOAD_LAT - 2) : 3'd0;

  state_t           state_q, state_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [4:0]       rd_ex_q, rd_ex_d;
  logic             ld_ex_q, ld_ex_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             haz;
  logic             stall_evt;
  logic             flush_evt;

  assign haz = ld_ex_q & (rd_ex_q != 5'd0) &
               ((uses_rs1_id & (rs1_id == rd_ex_q)) |
                (uses_rs2_id & (rs2_id == rd_ex_q)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      lat_cnt_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    unique case (state_q)
      RUN: begin
        if (!br_taken_ex && haz && MULTI_STALL) begin
          state_d   = STALL;
          lat_cnt_d = LAT_INIT;
        end
      end
      STALL: begin
        // EX holds only bubbles here, so a branch indication cannot be genuine
        if (lat_cnt_q == 3'd0) begin
          state_d = RUN;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    stall_evt  = 1'b0;
    flush_evt  = 1'b0;
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state_q)
        RUN: begin
          if (br_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_evt  = 1'b1;
          end else if (haz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            stall_evt  = 1'b1;
          end
        end
        STALL: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          stall_evt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A flushed ID/EX slot is a bubble, so the shadow must forget the destination too
  always_comb begin
    rd_ex_d     = idex_flush ? 5'd0 : rd_id;
    ld_ex_d     = idex_flush ? 1'b0 : (DMRd_id & RuWr_id);
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_evt && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_evt && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ex_q     <= 5'd0;
      ld_ex_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      rd_ex_q     <= rd_ex_d;
      ld_ex_q     <= ld_ex_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Three configurations share one stimulus stream; a per-cycle scoreboard checks each against a behavioural model.
module tb_hazard_detection_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_id;
  logic       uses_rs1_id, uses_rs2_id, RuWr_id, DMRd_id, br_taken_ex;

  logic [3:0]  a_ctl, b_ctl, c_ctl;
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [3:0]  c_scnt, c_fcnt;

  hazard_detection_unit #(.LOAD_LAT(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .RuWr_id(RuWr_id),
    .DMRd_id(DMRd_id), .br_taken_ex(br_taken_ex),
    .pc_en(a_ctl[3]), .ifid_en(a_ctl[2]), .ifid_flush(a_ctl[1]), .idex_flush(a_ctl[0]),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

  hazard_detection_unit #(.LOAD_LAT(3), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .RuWr_id(RuWr_id),
    .DMRd_id(DMRd_id), .br_taken_ex(br_taken_ex),
    .pc_en(b_ctl[3]), .ifid_en(b_ctl[2]), .ifid_flush(b_ctl[1]), .idex_flush(b_ctl[0]),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

  hazard_detection_unit #(.LOAD_LAT(1), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .uses_rs1_id(uses_rs1_id), .uses_rs2_id(uses_rs2_id), .RuWr_id(RuWr_id),
    .DMRd_id(DMRd_id), .br_taken_ex(br_taken_ex),
    .pc_en(c_ctl[3]), .ifid_en(c_ctl[2]), .ifid_flush(c_ctl[1]), .idex_flush(c_ctl[0]),
    .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

  typedef struct {
    int stall_left;
    int rd_ex;
    bit ld_ex;
    int scnt;
    int fcnt;
  } mstate_t;

  typedef struct {
    bit [3:0] ctl;
    int       scnt;
    int       fcnt;
  } mout_t;

  typedef struct {
    int    cyc;
    mout_t a;
    mout_t b;
    mout_t c;
  } exp_t;

  exp_t    sb_q[$];
  mstate_t ma, mb, mc;
  int      tests = 0;
  int      fails = 0;
  int      cyc_no = 0;

  // ctl = {pc_en, ifid_en, ifid_flush, idex_flush}; counters are the values registered so far
  function automatic void model(input int lat, input int cmax, input mstate_t mi,
                                output mstate_t mo, output mout_t o);
    bit haz;
    mo     = mi;
    o.scnt = mi.scnt;
    o.fcnt = mi.fcnt;
    haz = mi.ld_ex && (mi.rd_ex != 0) &&
          ((uses_rs1_id && int'(rs1_id) == mi.rd_ex) ||
           (uses_rs2_id && int'(rs2_id) == mi.rd_ex));
    if (rst) begin
      o.ctl = 4'b0011;
      mo.stall_left = 0; mo.rd_ex = 0; mo.ld_ex = 0; mo.scnt = 0; mo.fcnt = 0;
    end else if (mi.stall_left > 0) begin
      o.ctl = 4'b0001;
      mo.stall_left = mi.stall_left - 1;
      mo.scnt = (mi.scnt < cmax) ? mi.scnt + 1 : mi.scnt;
      mo.rd_ex = 0; mo.ld_ex = 0;
    end else if (br_taken_ex) begin
      o.ctl = 4'b1111;
      mo.fcnt = (mi.fcnt < cmax) ? mi.fcnt + 1 : mi.fcnt;
      mo.rd_ex = 0; mo.ld_ex = 0;
    end else if (haz) begin
      o.ctl = 4'b0001;
      mo.stall_left = lat - 1;
      mo.scnt = (mi.scnt < cmax) ? mi.scnt + 1 : mi.scnt;
      mo.rd_ex = 0; mo.ld_ex = 0;
    end else begin
      o.ctl = 4'b1100;
      mo.rd_ex = int'(rd_id);
      mo.ld_ex = DMRd_id && RuWr_id;
    end
  endfunction

  task automatic cyc(input bit r, input logic [4:0] s1, input bit u1, input logic [4:0] s2,
                     input bit u2, input logic [4:0] d, input bit wr, input bit ld, input bit br);
    exp_t    e;
    mstate_t nxt;
    @(posedge clk);
    #1;
    rst = r; rs1_id = s1; uses_rs1_id = u1; rs2_id = s2; uses_rs2_id = u2;
    rd_id = d; RuWr_id = wr; DMRd_id = ld; br_taken_ex = br;
    e.cyc = cyc_no;
    model(1, 65535, ma, nxt, e.a); ma = nxt;
    model(3, 65535, mb, nxt, e.b); mb = nxt;
    model(1, 15,    mc, nxt, e.c); mc = nxt;
    sb_q.push_back(e);
    cyc_no++;
  endtask

  task automatic idle();
    cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
  endtask

  task automatic lw(input logic [4:0] d);
    cyc(0, 5'd1, 1, 5'd0, 0, d, 1, 1, 0);
  endtask

  task automatic check(input string nm, input int c, input logic [3:0] ctl,
                       input logic [15:0] s, input logic [15:0] f, input mout_t x);
    logic [35:0] got, need;
    got  = {ctl, s, f};
    need = {x.ctl, 16'(x.scnt), 16'(x.fcnt)};
    tests++;
    if (got !== need) begin
      fails++;
      $display("FAIL %s cycle %0d: ctl=%b stall_cnt=%0d flush_cnt=%0d, expected ctl=%b stall_cnt=%0d flush_cnt=%0d",
               nm, c, ctl, s, f, x.ctl, x.scnt, x.fcnt);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check("lat1", e.cyc, a_ctl, a_scnt, a_fcnt, e.a);
      check("lat3", e.cyc, b_ctl, b_scnt, b_fcnt, e.b);
      check("sat4", e.cyc, c_ctl, {12'd0, c_scnt}, {12'd0, c_fcnt}, e.c);
    end
  end

  initial begin
    ma = '{0, 0, 0, 0, 0};
    mb = '{0, 0, 0, 0, 0};
    mc = '{0, 0, 0, 0, 0};
    rst = 1'b1; rs1_id = 5'd0; rs2_id = 5'd0; rd_id = 5'd0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; RuWr_id = 1'b0; DMRd_id = 1'b0; br_taken_ex = 1'b0;
    @(posedge clk);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    repeat (2) idle();

    // load-use on rs1; the dependent add is held in ID for a few cycles
    lw(5'd5);
    repeat (4) cyc(0, 5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);
    repeat (3) idle();

    // x0 destination, then unused rs2 operand
    lw(5'd0);
    cyc(0, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0, 0);
    lw(5'd5);
    cyc(0, 5'd1, 1, 5'd5, 0, 5'd6, 1, 0, 0);
    repeat (3) idle();

    // taken branch, then a reader of the stale rd
    cyc(0, 5'd0, 0, 5'd0, 0, 5'd9, 1, 0, 0);
    cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    cyc(0, 5'd9, 1, 5'd9, 1, 5'd3, 1, 0, 0);
    idle();

    // branch and load-use in the same cycle
    lw(5'd7);
    cyc(0, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 1);
    repeat (3) idle();

    // branch pulsed in the middle of a long stall
    lw(5'd5);
    cyc(0, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    cyc(0, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 1);
    repeat (3) cyc(0, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    repeat (2) idle();

    // reset asserted in the second stall cycle
    lw(5'd5);
    cyc(0, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    cyc(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0);
    cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    repeat (3) idle();

    // enough load-use events to saturate the narrow counters
    for (int i = 0; i < 20; i++) begin
      lw(5'd3);
      cyc(0, 5'd3, 1, 5'd0, 0, 5'd4, 1, 0, 0);
      repeat (3) idle();
      cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 1);
    end
    repeat (4) idle();

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(63) == 0,
          5'($urandom_range(7)), 1'($urandom_range(1)),
          5'($urandom_range(7)), 1'($urandom_range(1)),
          5'($urandom_range(7)), $urandom_range(3) != 0,
          $urandom_range(1) == 0, $urandom_range(7) == 0);
    end

    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
